// File: rtl/ir_pkg.sv
// ir_pkg: NEC IR state encoding and timing constants shared by ir_tx and ir_rx.
package ir_pkg;
    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
    } ir_state_e;

    localparam int NEC_LEAD_MARK_US  = 9000;
    localparam int NEC_LEAD_SPACE_US = 4500;
    localparam int NEC_BIT_MARK_US   = 560;
    localparam int NEC_ZERO_SPACE_US = 560;
    localparam int NEC_ONE_SPACE_US  = 1690;
    localparam int NEC_GAP_US        = 40000;
    // receiver decision thresholds, kept next to the transmit timings they discriminate
    localparam int NEC_LEAD_MIN_US   = 8500;
    localparam int NEC_LSPACE_MIN_US = 4000;
    localparam int NEC_ONE_MIN_US    = 1000;

    function automatic logic is_mark(input ir_state_e s);
        return s == LEAD_MARK || s == BIT_MARK || s == STOP_MARK;
    endfunction
endpackage

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: carrier phase counter with synchronous restart; high for the first DIV/2 clocks.
module ir_carrier_gen #(
    parameter int DIV = 1316
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic en,
    output logic carrier
);
    localparam int W = $clog2(DIV + 1);
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    localparam logic [W-1:0] HALF = W'(DIV / 2);
    logic [W-1:0] phase, phase_nxt;
    always_comb phase_nxt = restart ? '0 : !en ? phase : phase == LAST ? '0 : phase + W'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            carrier <= 1'b0;
        end else begin
            phase <= phase_nxt;
            carrier <= phase_nxt < HALF;
        end
    end
endmodule

// File: rtl/ir_tx.sv
// ir_tx: NEC IR transmitter; sends a 32-bit word MSB first as leader, pulse-distance bits,
// stop mark and inter-frame gap, with a 38 kHz modulated LED drive and a plain envelope.
module ir_tx
    import ir_pkg::*;
#(
    parameter int CLK_PER_US    = 50,
    parameter int CARRIER_DIV   = 1316,
    parameter int LEAD_MARK_US  = NEC_LEAD_MARK_US,
    parameter int LEAD_SPACE_US = NEC_LEAD_SPACE_US,
    parameter int BIT_MARK_US   = NEC_BIT_MARK_US,
    parameter int ZERO_SPACE_US = NEC_ZERO_SPACE_US,
    parameter int ONE_SPACE_US  = NEC_ONE_SPACE_US,
    parameter int GAP_US        = NEC_GAP_US
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [31:0] i_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_ir_env,
    output logic        o_ir_tx
);
    localparam int PW = $clog2(CLK_PER_US + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_US - 1);
    ir_state_e state, nstate;
    logic [PW-1:0] pre_cnt, pre_nxt;
    logic [15:0] seg_cnt, seg_nxt, dur;
    logic [31:0] shift_reg;
    logic [4:0] bit_cnt;
    logic seg_end, restart, carrier;

    always_comb begin
        dur = state == LEAD_MARK ? 16'(LEAD_MARK_US) :
              state == LEAD_SPACE ? 16'(LEAD_SPACE_US) :
              state == BIT_SPACE ? (shift_reg[31] ? 16'(ONE_SPACE_US) : 16'(ZERO_SPACE_US)) :
              state == GAP ? 16'(GAP_US) : 16'(BIT_MARK_US);
        seg_end = pre_cnt == PRE_MAX && seg_cnt == dur - 16'd1;
        nstate = state;
        case (state)
            IDLE:       if (i_start) nstate = LEAD_MARK;
            LEAD_MARK:  if (seg_end) nstate = LEAD_SPACE;
            LEAD_SPACE: if (seg_end) nstate = BIT_MARK;
            BIT_MARK:   if (seg_end) nstate = BIT_SPACE;
            BIT_SPACE:  if (seg_end) nstate = bit_cnt == 5'd31 ? STOP_MARK : BIT_MARK;
            STOP_MARK:  if (seg_end) nstate = GAP;
            GAP:        if (seg_end) nstate = IDLE;
            default:    nstate = IDLE;
        endcase
        // both timers restart on every state entry and rest at zero while idle
        restart = nstate != state || nstate == IDLE;
        pre_nxt = restart || pre_cnt == PRE_MAX ? '0 : pre_cnt + PW'(1);
        seg_nxt = restart ? '0 : pre_cnt == PRE_MAX ? seg_cnt + 16'd1 : seg_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pre_cnt <= '0;
            seg_cnt <= '0;
            shift_reg <= '0;
            bit_cnt <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_ir_env <= 1'b0;
        end else begin
            state <= nstate;
            pre_cnt <= pre_nxt;
            seg_cnt <= seg_nxt;
            o_busy <= nstate != IDLE;
            o_ir_env <= is_mark(nstate);
            // registered lookahead: high during the final clock of GAP
            o_done <= nstate == GAP && pre_nxt == PRE_MAX && seg_nxt == 16'(GAP_US - 1);
            if (state == IDLE && i_start) begin
                shift_reg <= i_data;
                bit_cnt <= '0;
            end else if (state == BIT_SPACE && seg_end) begin
                shift_reg <= {shift_reg[30:0], 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    ir_carrier_gen #(.DIV(CARRIER_DIV)) u_carrier (
        .clk(clk),
        .rst_n(rst_n),
        .restart(is_mark(nstate) && nstate != state),
        .en(is_mark(nstate)),
        .carrier(carrier)
    );

    assign o_ir_tx = o_ir_env & carrier;
endmodule

// File: tb/tb_ir_tx.sv
// tb_ir_tx: scoreboard bench for ir_tx with shortened NEC timings; envelope segments are
// predicted per frame and checked as they complete, carrier checked every clock.
module tb_ir_tx;
    localparam int CPU = 2;
    localparam int DIV = 6;
    localparam int LM = 18;
    localparam int LS = 9;
    localparam int BM = 3;
    localparam int ZS = 3;
    localparam int OS = 8;
    localparam int GP = 20;

    typedef struct {
        logic lvl;
        int   len;
    } seg_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_start = 1'b0;
    logic [31:0] i_data = '0;
    logic o_busy, o_done, o_ir_env, o_ir_tx;

    seg_t q[$];
    int vectors = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;
    int exp_len = 0;
    int done_cnt = 0;
    bit mon_off = 1'b0;

    ir_tx #(
        .CLK_PER_US(CPU), .CARRIER_DIV(DIV), .LEAD_MARK_US(LM), .LEAD_SPACE_US(LS),
        .BIT_MARK_US(BM), .ZERO_SPACE_US(ZS), .ONE_SPACE_US(OS), .GAP_US(GP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_start(i_start),
        .i_data(i_data),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_ir_env(o_ir_env),
        .o_ir_tx(o_ir_tx)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int frame_len(input logic [31:0] d);
        int n;
        n = CPU * (LM + LS + BM + GP);
        for (int i = 0; i < 32; i++) n += CPU * (BM + (d[i] ? OS : ZS));
        return n;
    endfunction

    task automatic push_frame(input logic [31:0] d);
        q.push_back('{1'b1, CPU * LM});
        q.push_back('{1'b0, CPU * LS});
        for (int i = 31; i >= 0; i--) begin
            q.push_back('{1'b1, CPU * BM});
            q.push_back('{1'b0, CPU * (d[i] ? OS : ZS)});
        end
        q.push_back('{1'b1, CPU * BM});
    endtask

    // called at a negedge; start is accepted at the following posedge
    task automatic start_frame(input logic [31:0] d);
        i_start = 1'b1;
        i_data = d;
        push_frame(d);
        exp_len = frame_len(d);
        @(posedge clk);
        @(negedge clk);
        t0 = cyc;
        i_start = 1'b0;
        i_data = ~d;
        check("busy_after_accept", 32'(o_busy), 32'd1);
        check("env_after_accept", 32'(o_ir_env), 32'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (o_done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(n < 2000), 32'd1);
        check("frame_len", 32'(cyc - t0 + 1), 32'(exp_len));
    endtask

    // monitor: envelope run lengths against the scoreboard, carrier against a phase model
    initial begin
        logic pe;
        int run;
        int mc;
        seg_t s;
        pe = 1'b0;
        run = 0;
        mc = 0;
        forever begin
            @(negedge clk);
            if (mon_off || !rst_n) begin
                pe = 1'b0;
                run = 0;
                mc = 0;
            end else begin
                if (o_done === 1'b1) done_cnt++;
                check("carrier", 32'(o_ir_tx), 32'(o_ir_env === 1'b1 && (mc % DIV) < DIV / 2));
                mc = o_ir_env === 1'b1 ? mc + 1 : 0;
                if (o_ir_env !== pe) begin
                    if (q.size() > 0 && q[0].lvl == pe) begin
                        s = q.pop_front();
                        check(pe ? "mark_len" : "space_len", 32'(run), 32'(s.len));
                    end
                    run = 0;
                end
                pe = o_ir_env;
                run++;
            end
        end
    end

    initial begin
        int rises;
        int busy_seen;
        logic pe;
        // reset with start held high
        i_start = 1'b1;
        i_data = 32'h00FF_A55A;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_env", 32'(o_ir_env), 32'd0);
        check("rst_tx", 32'(o_ir_tx), 32'd0);
        i_start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(o_busy), 32'd0);

        // frame A, then one-cycle done
        start_frame(32'h00FF_A55A);
        wait_done();
        @(negedge clk);
        check("done_single", 32'(o_done), 32'd0);
        check("busy_end", 32'(o_busy), 32'd0);

        // frame B with a stray start mid-frame, then a start held across the done edge
        start_frame(32'h1234_5678);
        repeat (150) @(negedge clk);
        i_start = 1'b1;
        i_data = 32'hDEAD_BEEF;
        @(negedge clk);
        i_start = 1'b0;
        wait_done();
        i_start = 1'b1;
        i_data = 32'hA5A5_0F0F;
        @(negedge clk);
        check("done_cycle_start_ignored", 32'(o_busy), 32'd0);
        start_frame(32'hA5A5_0F0F);
        wait_done();
        busy_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (o_busy !== 1'b0) busy_seen++;
        end
        check("no_extra_frame", 32'(busy_seen), 32'd0);
        check("done_count_3", 32'(done_cnt), 32'd3);
        check("queue_drained", 32'(q.size()), 32'd0);

        // abort with reset during the bit-10 mark
        start_frame(32'hF0F0_1234);
        rises = 1;
        pe = 1'b1;
        for (int n = 0; n < 2000 && rises < 12; n++) begin
            @(negedge clk);
            if (o_ir_env === 1'b1 && pe !== 1'b1) rises++;
            pe = o_ir_env;
        end
        check("bit10_reached", 32'(rises), 32'd12);
        mon_off = 1'b1;
        @(posedge clk);
        #2;
        check("env_before_abort", 32'(o_ir_env), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_env", 32'(o_ir_env), 32'd0);
        check("abort_tx", 32'(o_ir_tx), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_done", 32'(o_done), 32'd0);
        rst_n = 1'b1;
        q.delete();
        @(negedge clk);
        mon_off = 1'b0;
        check("done_count_abort", 32'(done_cnt), 32'd3);

        // full frame after abort
        @(negedge clk);
        start_frame(32'h8000_0001);
        wait_done();
        @(negedge clk);
        check("done_single_e", 32'(o_done), 32'd0);
        check("done_count_4", 32'(done_cnt), 32'd4);
        check("queue_drained_e", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/ir_tx.md
Name: ir_tx

Overview:
- NEC-format IR transmitter: the transmit end of the IR link whose receive end is `ir_rx`.
- On a start request it serialises a 32-bit custom/data word into:
  - a leader (9 ms mark, 4.5 ms space),
  - 32 pulse-distance bits,
  - a stop mark,
  - a mandatory inter-frame gap.
- Output is a 38 kHz-modulated drive for an IR LED, plus an unmodulated envelope for loop-back into `ir_rx` (inverted externally to form `i_ir_rxb`).

Parameters:
- CLK_PER_US, 50, system clocks per 1 us timing tick (50 MHz clk).
- CARRIER_DIV, 1316, clocks per carrier period (about 38 kHz); high for CARRIER_DIV/2, low for the remainder.
- LEAD_MARK_US, 9000, leader mark duration.
- LEAD_SPACE_US, 4500, leader space duration.
- BIT_MARK_US, 560, mark preceding every data bit and the stop mark.
- ZERO_SPACE_US, 560, space after the mark for a 0 bit.
- ONE_SPACE_US, 1690, space after the mark for a 1 bit.
- GAP_US, 40000, idle space after the stop mark before o_done.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle or level request; sampled only in IDLE
- i_data  in  32  frame word; bit 31 transmitted first
- o_busy  out  1  high from the cycle after accepted start through the end of GAP
- o_done  out  1  one-cycle pulse in the last GAP cycle
- o_ir_env  out  1  envelope, 1 = mark
- o_ir_tx  out  1  carrier-modulated envelope (o_ir_env AND carrier)

Behaviour:
- Reset (asynchronous, immediate on rst_n low):
  - state IDLE.
  - o_busy, o_done, o_ir_env and o_ir_tx all 0.
  - All counters and the shift register cleared.
  - Reset mid-frame aborts the frame with no o_done; output goes low without waiting for a clock.
- States and transitions:
  - IDLE: if i_start=1 at a posedge, latch i_data into shift_reg, clear bit_cnt, go to LEAD_MARK.
  - LEAD_MARK, LEAD_MARK_US long, then LEAD_SPACE.
  - LEAD_SPACE, LEAD_SPACE_US long, then BIT_MARK.
  - BIT_MARK, BIT_MARK_US long, then BIT_SPACE.
  - BIT_SPACE lasts ONE_SPACE_US if shift_reg[31]=1, else ZERO_SPACE_US. At its end: shift left by 1 and increment bit_cnt. If bit_cnt was 31, go to STOP_MARK; else go to BIT_MARK.
  - STOP_MARK, BIT_MARK_US long, then GAP.
  - GAP, GAP_US long; o_done=1 in its last clock, then IDLE.
- Timing:
  - The us prescaler (0..CLK_PER_US-1) and the us segment counter restart on every state entry.
  - Each segment is therefore exactly duration×CLK_PER_US clocks.
  - Segment counter is 16 bits; durations must not exceed 65535.
- Registered outputs:
  - o_ir_env = 1 exactly in LEAD_MARK, BIT_MARK and STOP_MARK.
  - o_ir_env, o_busy and o_done change in the clock following the state-decision edge. o_ir_env rises the cycle after i_start is accepted.
- Carrier:
  - Phase counter (0..CARRIER_DIV-1) restarts at 0 on entry to any mark state, so every mark starts with carrier high.
  - Free-running within the mark.
  - o_ir_tx = 0 whenever o_ir_env = 0.
- Handshake:
  - i_start is ignored while busy (including GAP and the o_done cycle).
  - i_data is sampled only on acceptance; later changes have no effect on the frame in flight.
  - A start asserted in the cycle after o_done is accepted.
- Frame length:
  - 13500 + Σbits(560 + space) + 560 + GAP_US microseconds.
  - Example: all-zero word = 49900 us + gap.

Decomposition:
- Shared package `ir_pkg` holds:
  - state encoding (3-bit: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP);
  - NEC timing constants (the us durations above);
  - the 8500/4000/1000 us thresholds used by the receiver, so both ends share one source.
- One natural sub-module, `ir_carrier_gen`: carrier phase counter with synchronous restart, enable and 50% duty output. Prescaler and FSM stay in `ir_tx`.

Test Plan:
- Reset with i_start held high -> outputs 0. After release, one start pulse with i_data=32'h00FF_A55A -> o_ir_env high exactly 450000 clocks, then low 225000 clocks. o_busy high the cycle after acceptance.
- Same frame: measure each bit's space -> 28000 clocks for 0 bits and 84500 clocks for 1 bits, in MSB-first order matching 0x00FFA55A. Stop mark 28000 clocks. o_done single pulse after 2,000,000 gap clocks.
- Loop-back: o_ir_env inverted into an `ir_rx` instance, i_data=32'h1234_5678 -> receiver o_data=32'h1234_5678 after completion.
- o_ir_tx during leader -> first clock of mark high, period 1316 clocks (658 high / 658 low). o_ir_tx=0 throughout every space.
- i_start pulsed mid-frame with different i_data -> frame bits unchanged, no extra frame. Start pulsed the cycle after o_done -> new frame begins.
- rst_n dropped during bit 10 of a frame -> o_ir_env/o_ir_tx/o_busy go 0 asynchronously, no o_done. Next start produces a full correct frame.
